// File: rtl/glyph_font_pkg.sv
// glyph_font_pkg
// Shared 8x7 character-cell font used by both the scrolling column generator
// and the receive-side glyph_column_decoder. Each glyph is eight 7-bit
// columns; bit 0 of a column is the top pixel. Code = ASCII - 0x20.
// No ports (package).
package glyph_font_pkg;

  localparam int CELL_COLS = 8;
  localparam int NGLYPH    = 64;

  typedef logic [5:0] char_code_t;
  typedef logic [NGLYPH-1:0][CELL_COLS-1:0][6:0] font_t;

  // One glyph per line, column 0 in the most significant byte, so the hex
  // literal reads left-to-right in the order the columns arrive.
  function automatic logic [63:0] glyph_rows(int g);
    case (g)
      0:       glyph_rows = 64'h00_00_00_00_00_00_00_00;  // ' '
      13:      glyph_rows = 64'h00_08_08_08_08_08_00_00;  // '-'
      16:      glyph_rows = 64'h00_3E_61_51_49_45_3E_00;  // '0'
      17:      glyph_rows = 64'h00_44_42_7F_40_40_00_00;  // '1'
      18:      glyph_rows = 64'h00_62_51_49_49_46_00_00;  // '2'
      19:      glyph_rows = 64'h00_22_41_49_49_36_00_00;  // '3'
      20:      glyph_rows = 64'h00_18_14_12_7F_10_00_00;  // '4'
      21:      glyph_rows = 64'h00_27_45_45_45_39_00_00;  // '5'
      22:      glyph_rows = 64'h00_3C_4A_49_49_30_00_00;  // '6'
      23:      glyph_rows = 64'h00_01_71_09_05_03_00_00;  // '7'
      24:      glyph_rows = 64'h00_36_49_49_49_36_00_00;  // '8'
      25:      glyph_rows = 64'h00_06_49_49_29_1E_00_00;  // '9'
      33:      glyph_rows = 64'h00_7C_12_11_11_12_7C_00;  // 'A'
      34:      glyph_rows = 64'h00_7F_49_49_49_36_00_00;  // 'B'
      35:      glyph_rows = 64'h00_3E_41_41_41_22_00_00;  // 'C'
      36:      glyph_rows = 64'h00_7F_41_41_22_1C_00_00;  // 'D'
      37:      glyph_rows = 64'h00_7F_49_49_49_41_00_00;  // 'E'
      38:      glyph_rows = 64'h00_7F_09_09_09_01_00_00;  // 'F'
      default: glyph_rows = 64'h0;
    endcase
  endfunction

  // Space is all-zero, so definedness cannot be inferred from the pixel data.
  function automatic logic [NGLYPH-1:0] defined_mask();
    logic [NGLYPH-1:0] m;
    m     = '0;
    m[0]  = 1'b1;
    m[13] = 1'b1;
    for (int g = 16; g <= 25; g++) m[g] = 1'b1;
    for (int g = 33; g <= 38; g++) m[g] = 1'b1;
    return m;
  endfunction

  function automatic font_t build_font();
    font_t       f;
    logic [63:0] r;
    f = '0;
    for (int g = 0; g < NGLYPH; g++) begin
      r = glyph_rows(g);
      for (int k = 0; k < CELL_COLS; k++) f[g][k] = r[8*(CELL_COLS-1-k) +: 7];
    end
    return f;
  endfunction

  localparam font_t             FONT          = build_font();
  localparam logic [NGLYPH-1:0] GLYPH_DEFINED = defined_mask();

endpackage

// File: rtl/glyph_col_match.sv
// glyph_col_match
// Compares one received column against column col_sel of every font glyph.
// Font data are constants, so each hit bit reduces to a 7-bit constant
// compare selected by col_sel.
// Ports:
//   col_in  [6:0]        received column pattern
//   col_sel [2:0]        column index within the cell
//   hit     [NGLYPH-1:0] hit[g] = col_in equals FONT[g][col_sel]
module glyph_col_match
  import glyph_font_pkg::*;
(
  input  logic [6:0]        col_in,
  input  logic [2:0]        col_sel,
  output logic [NGLYPH-1:0] hit
);

  always_comb begin
    hit = '0;
    for (int g = 0; g < NGLYPH; g++) hit[g] = (col_in == FONT[g][col_sel]);
  end

endmodule

// File: rtl/glyph_column_decoder.sv
// glyph_column_decoder
// Reassembles 8-column character cells from a column stream and reports the
// matching font glyph. Matching is incremental: a candidate mask is narrowed
// on every beat, so no column history is stored.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   col_in     column pattern, bit 0 = top pixel
//   col_valid  col_in valid this cycle
//   cell_sync  with col_valid: this beat is column 0 of a cell
//   char_code  last decoded code (ASCII - 0x20), held between matches
//   char_valid one-cycle pulse, char_code updated with a matched glyph
//   char_miss  one-cycle pulse, completed cell matched nothing
//   cell_abort one-cycle pulse, partial cell dropped by cell_sync
//   locked     a cell boundary has been seen since reset
module glyph_column_decoder
  import glyph_font_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] col_in,
  input  logic       col_valid,
  input  logic       cell_sync,
  output char_code_t char_code,
  output logic       char_valid,
  output logic       char_miss,
  output logic       cell_abort,
  output logic       locked
);

  localparam logic [2:0] LAST_COL = 3'(CELL_COLS - 1);

  logic [2:0]        col_idx;
  logic [2:0]        k;
  logic [NGLYPH-1:0] cand;
  logic [NGLYPH-1:0] hit;
  logic [NGLYPH-1:0] base;
  logic [NGLYPH-1:0] cand_next;
  logic              beat_en;
  char_code_t        first_code;

  // A sync beat always restarts the cell at column 0, whatever col_idx holds.
  assign k         = cell_sync ? 3'd0 : col_idx;
  assign beat_en   = col_valid && (locked || cell_sync);
  assign base      = (k == 3'd0) ? GLYPH_DEFINED : cand;
  assign cand_next = base & hit;

  glyph_col_match u_match (
    .col_in  (col_in),
    .col_sel (k),
    .hit     (hit)
  );

  // Lowest set bit wins so that ties resolve to the smaller code.
  always_comb begin
    first_code = '0;
    for (int g = NGLYPH - 1; g >= 0; g--) begin
      if (cand_next[g]) first_code = char_code_t'(g);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx    <= 3'd0;
      cand       <= GLYPH_DEFINED;
      locked     <= 1'b0;
      char_code  <= '0;
      char_valid <= 1'b0;
      char_miss  <= 1'b0;
      cell_abort <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      char_miss  <= 1'b0;
      cell_abort <= 1'b0;
      if (beat_en) begin
        locked <= 1'b1;
        if (cell_sync && (col_idx != 3'd0)) cell_abort <= 1'b1;
        if (k == LAST_COL) begin
          if (|cand_next) begin
            char_code  <= first_code;
            char_valid <= 1'b1;
          end else begin
            char_miss <= 1'b1;
          end
          col_idx <= 3'd0;
          cand    <= GLYPH_DEFINED;
        end else begin
          col_idx <= k + 3'd1;
          cand    <= cand_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_glyph_column_decoder.sv
// tb_glyph_column_decoder
// Directed cells from the test plan followed by randomized cells, partial
// cells, gaps and resets. The reference model buffers the columns of the
// current cell in a queue and, once eight are collected, searches the font
// for the first defined glyph whose columns all equal the buffered ones.
module tb_glyph_column_decoder;
  import glyph_font_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] col_in = '0;
  logic       col_valid = 1'b0;
  logic       cell_sync = 1'b0;
  char_code_t char_code;
  logic       char_valid, char_miss, cell_abort, locked;

  int n_checks = 0;
  int n_pass   = 0;

  bit         m_locked = 1'b0;
  logic [6:0] m_cols[$];
  int         m_code = 0;
  bit         e_valid = 1'b0, e_miss = 1'b0, e_abort = 1'b0;
  int         defs[$];

  localparam logic [63:0] ROW_ZERO  = 64'h00_3E_61_51_49_45_3E_00;
  localparam logic [63:0] ROW_A     = 64'h00_7C_12_11_11_12_7C_00;
  localparam logic [63:0] ROW_ONE   = 64'h00_44_42_7F_40_40_00_00;
  localparam logic [63:0] ROW_SPACE = 64'h0;
  localparam logic [63:0] ROW_FULL  = 64'h7F_7F_7F_7F_7F_7F_7F_7F;

  glyph_column_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_in     (col_in),
    .col_valid  (col_valid),
    .cell_sync  (cell_sync),
    .char_code  (char_code),
    .char_valid (char_valid),
    .char_miss  (char_miss),
    .cell_abort (cell_abort),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_code"},   32'(char_code),  32'(m_code));
    check({tag, "_valid"},  32'(char_valid), 32'(e_valid));
    check({tag, "_miss"},   32'(char_miss),  32'(e_miss));
    check({tag, "_abort"},  32'(cell_abort), 32'(e_abort));
    check({tag, "_locked"}, 32'(locked),     32'(m_locked));
  endtask

  task automatic model_step(input logic [6:0] col, input bit sync);
    int found;
    bit same;
    e_valid = 1'b0;
    e_miss  = 1'b0;
    e_abort = 1'b0;
    if (!m_locked && !sync) return;
    m_locked = 1'b1;
    if (sync) begin
      if (m_cols.size() != 0) e_abort = 1'b1;
      m_cols.delete();
    end
    m_cols.push_back(col);
    if (m_cols.size() == CELL_COLS) begin
      found = -1;
      for (int g = 0; g < NGLYPH; g++) begin
        if (found < 0 && GLYPH_DEFINED[g]) begin
          same = 1'b1;
          for (int c = 0; c < CELL_COLS; c++) if (FONT[g][c] != m_cols[c]) same = 1'b0;
          if (same) found = g;
        end
      end
      if (found >= 0) begin
        e_valid = 1'b1;
        m_code  = found;
      end else begin
        e_miss = 1'b1;
      end
      m_cols.delete();
    end
  endtask

  task automatic beat(input logic [6:0] col, input bit sync);
    @(negedge clk);
    col_in    = col;
    cell_sync = sync;
    col_valid = 1'b1;
    model_step(col, sync);
    @(posedge clk);
    #1;
    check_outputs("beat");
  endtask

  // Idle cycles drive junk on col_in/cell_sync to show they are ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      col_valid = 1'b0;
      col_in    = 7'($urandom);
      cell_sync = 1'($urandom);
      e_valid   = 1'b0;
      e_miss    = 1'b0;
      e_abort   = 1'b0;
      @(posedge clk);
      #1;
      check_outputs("idle");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    col_valid = 1'b0;
    cell_sync = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_locked = 1'b0;
    m_cols.delete();
    m_code  = 0;
    e_valid = 1'b0;
    e_miss  = 1'b0;
    e_abort = 1'b0;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] glyph_row(input int g);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < CELL_COLS; c++) r[8*(CELL_COLS-1-c) +: 7] = FONT[g][c];
    return r;
  endfunction

  // Sends columns first..last-1 of a cell, sync on the first one if asked.
  task automatic send_row(input logic [63:0] r, input int first, input int last,
                          input bit sync_first, input int max_gap);
    for (int c = first; c < last; c++) begin
      beat(r[8*(CELL_COLS-1-c) +: 7], sync_first && (c == first));
      if (c < last - 1 && max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int          g;
    int          n;
    logic [63:0] r;

    for (int i = 0; i < NGLYPH; i++) if (GLYPH_DEFINED[i]) defs.push_back(i);

    do_reset();
    idle(2);

    // Unlocked: columns without sync are ignored.
    for (int i = 0; i < 5; i++) beat(7'($urandom), 1'b0);
    check("t4_unlocked", 32'(locked), 32'd0);

    // '0' with sync.
    send_row(ROW_ZERO, 0, 8, 1'b1, 0);
    check("t1_valid", 32'(char_valid), 32'd1);
    check("t1_code", 32'(char_code), 32'd16);
    idle(2);

    // 'A' then '1' back-to-back, sync on the first only.
    send_row(ROW_A, 0, 8, 1'b1, 0);
    check("t2_code_a", 32'(char_code), 32'd33);
    send_row(ROW_ONE, 0, 8, 1'b0, 0);
    check("t2_valid_1", 32'(char_valid), 32'd1);
    check("t2_code_1", 32'(char_code), 32'd17);

    // Space, then an undefined all-ones cell.
    send_row(ROW_SPACE, 0, 8, 1'b0, 0);
    check("t3_space_valid", 32'(char_valid), 32'd1);
    check("t3_space_code", 32'(char_code), 32'd0);
    send_row(ROW_FULL, 0, 8, 1'b0, 0);
    check("t3_miss", 32'(char_miss), 32'd1);
    check("t3_code_held", 32'(char_code), 32'd0);
    idle(1);

    // Partial cell cut short by a sync.
    send_row(ROW_ZERO, 0, 4, 1'b0, 0);
    send_row(ROW_A, 0, 1, 1'b1, 0);
    check("t5_abort", 32'(cell_abort), 32'd1);
    check("t5_no_valid", 32'(char_valid), 32'd0);
    send_row(ROW_A, 1, 8, 1'b0, 0);
    check("t5_code", 32'(char_code), 32'd33);
    idle(1);

    // Gaps, then reset in the middle of a cell.
    send_row(ROW_A, 0, 8, 1'b1, 5);
    check("t6_code", 32'(char_code), 32'd33);
    send_row(ROW_A, 0, 6, 1'b0, 0);
    do_reset();
    check("t6_locked_after_rst", 32'(locked), 32'd0);
    idle(4);
    send_row(ROW_A, 0, 8, 1'b0, 0);
    check("t6_still_unlocked", 32'(locked), 32'd0);

    // Randomized cells: defined glyphs, random patterns, partial cells, resets.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) r = {$urandom, $urandom} & 64'h7F7F7F7F7F7F7F7F;
      else begin
        g = defs[$urandom_range(0, defs.size() - 1)];
        r = glyph_row(g);
      end
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
      send_row(r, 0, n, 1'($urandom_range(0, 1)), 2);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 24) == 0) do_reset();
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
